// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner.
// Holds the matrix dimensions, the idle and reset patterns, the FSM state
// encoding, and small helpers for converting between one-hot vectors and
// indices.
package keypad_pkg;

    localparam int NROWS = 5;
    localparam int NCOLS = 4;

    localparam logic [NCOLS-1:0] COL_IDLE  = 4'b1111;
    localparam logic [NROWS-1:0] ROW_RESET = 5'b00001;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Index of the set bit in a one-hot vector (lowest set bit wins).
    function automatic logic [4:0] onehot_to_idx(input logic [7:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of vec is set.
    function automatic logic exactly_one(input logic [7:0] vec);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n = n + int'(vec[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the raw keypad column lines.
// Ports:
//   clk    in  1   system clock
//   rst_n  in  1   asynchronous active-low reset (flops reset to all ones,
//                  i.e. "no key pressed")
//   d      in  W   asynchronous input
//   q      out W   synchronized output
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// Keypad matrix scanner: strobes one row at a time, samples the active-low
// column lines, debounces a single-key press and its release, and presents
// the accepted key as a latched row/column pair plus a linear key code.
// Ports:
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   col_in     in   NCOLS  raw keypad columns, active-low
//   row_drive  out  NROWS  one-hot row strobe
//   rowOut     out  NROWS  row of the accepted key (one-hot)
//   colOut     out  NCOLS  column of the accepted key (one-cold)
//   key_code   out  5      row_index*NCOLS + col_index of the accepted key
//   key_valid  out  1      one-cycle pulse per accepted press
//   key_held   out  1      high from accept until the release is debounced
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCOLS-1:0] col_in,
    output logic [NROWS-1:0] row_drive,
    output logic [NROWS-1:0] rowOut,
    output logic [NCOLS-1:0] colOut,
    output logic [4:0]       key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    logic [NCOLS-1:0] col_s;

    keypad_sync #(.W(NCOLS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col_in),
        .q     (col_s)
    );

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] dwell_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [NROWS-1:0] row_reg;
    logic [NCOLS-1:0] cand_col_reg;
    logic [NROWS-1:0] row_out_reg;
    logic [NCOLS-1:0] col_out_reg;
    logic [4:0]       code_reg;
    logic             valid_reg;
    logic             held_reg;

    logic dwell_end;
    logic cnt_end;
    logic single_zero;
    logic cand_match;
    logic col_idle;

    assign dwell_end   = (dwell_reg == CNT_W'(SCAN_DIV - 1));
    assign cnt_end     = (cnt_reg == CNT_W'(DEBOUNCE_CNT - 1));
    // More than one low column on a row is treated as a ghost/multi-key and
    // skipped, so only a clean single press can become a candidate.
    assign single_zero = exactly_one({{(8-NCOLS){1'b0}}, ~col_s});
    assign cand_match  = (col_s == cand_col_reg);
    assign col_idle    = (col_s == COL_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SCAN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SCAN: begin
                if (dwell_end && single_zero) begin
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!cand_match) begin
                    state_next = SCAN;
                end else if (cnt_end) begin
                    state_next = HELD;
                end
            end
            HELD: begin
                if (col_idle && cnt_end) begin
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // Control strobes for the datapath
    logic capture, accept, release_key, rotate;
    logic dwell_inc, dwell_clr, cnt_inc, cnt_clr;

    always_comb begin
        capture     = 1'b0;
        accept      = 1'b0;
        release_key = 1'b0;
        rotate      = 1'b0;
        dwell_inc   = 1'b0;
        dwell_clr   = 1'b0;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        case (state_reg)
            SCAN: begin
                if (dwell_end) begin
                    dwell_clr = 1'b1;
                    if (single_zero) begin
                        capture = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        rotate = 1'b1;
                    end
                end else begin
                    dwell_inc = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!cand_match) begin
                    rotate    = 1'b1;
                    dwell_clr = 1'b1;
                end else if (cnt_end) begin
                    accept  = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HELD: begin
                if (!col_idle) begin
                    cnt_clr = 1'b1;
                end else if (cnt_end) begin
                    release_key = 1'b1;
                    rotate      = 1'b1;
                    dwell_clr   = 1'b1;
                    cnt_clr     = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                dwell_clr = 1'b1;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_reg    <= '0;
            cnt_reg      <= '0;
            row_reg      <= ROW_RESET;
            cand_col_reg <= COL_IDLE;
            row_out_reg  <= '0;
            col_out_reg  <= COL_IDLE;
            code_reg     <= '0;
            valid_reg    <= 1'b0;
            held_reg     <= 1'b0;
        end else begin
            if (dwell_clr) begin
                dwell_reg <= '0;
            end else if (dwell_inc) begin
                dwell_reg <= dwell_reg + 1'b1;
            end

            if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (cnt_inc) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (rotate) begin
                row_reg <= {row_reg[NROWS-2:0], row_reg[NROWS-1]};
            end

            if (capture) begin
                cand_col_reg <= col_s;
            end

            if (accept) begin
                row_out_reg <= row_reg;
                col_out_reg <= cand_col_reg;
                code_reg    <= 5'(int'(onehot_to_idx({{(8-NROWS){1'b0}}, row_reg})) * NCOLS
                                  + int'(onehot_to_idx({{(8-NCOLS){1'b0}}, ~cand_col_reg})));
            end

            valid_reg <= accept;

            if (accept) begin
                held_reg <= 1'b1;
            end else if (release_key) begin
                held_reg <= 1'b0;
            end
        end
    end

    assign row_drive = row_reg;
    assign rowOut    = row_out_reg;
    assign colOut    = col_out_reg;
    assign key_code  = code_reg;
    assign key_valid = valid_reg;
    assign key_held  = held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8. A small matrix
// model turns a table of pressed keys into column levels for whichever row
// is currently strobed; expectations come from the key coordinates.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DC  = 8;
    localparam int NR  = 5;
    localparam int NC  = 4;
    localparam int LAT = 2 + NR * SD + DC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] col_in = 4'hF;
    logic [NR-1:0] row_drive;
    logic [NR-1:0] row_out;
    logic [NC-1:0] col_out;
    logic [4:0]    key_code;
    logic          key_valid;
    logic          key_held;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_drive (row_drive),
        .rowOut    (row_out),
        .colOut    (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial forever #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    bit   pressed [NR][NC];
    int   cycle = 0;
    int   pulses = 0;
    int   pulse_cycle = 0;
    logic prev_valid = 1'b0;
    logic [4:0]    last_code;
    logic [NR-1:0] last_row;
    logic [NC-1:0] last_col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Column levels seen by the scanner: a pressed key pulls its column low
    // only while its row is strobed.
    task automatic apply_matrix();
        logic [NC-1:0] c;
        c = 4'hF;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NC; k++)
                if (pressed[r][k] && row_drive[r]) c[k] = 1'b0;
        col_in = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        check("row_onehot", 32'($countones(row_drive)), 32'd1);
        if (key_valid === 1'b1) begin
            pulses++;
            pulse_cycle = cycle;
            last_code = key_code;
            last_row = row_out;
            last_col = col_out;
            check("valid_pulse_width", {31'b0, prev_valid}, 32'd0);
        end
        prev_valid = key_valid;
        apply_matrix();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until row_drive has just switched to target.
    task automatic wait_row(input logic [NR-1:0] target);
        bit ok;
        logic [NR-1:0] prev;
        ok = 1'b0;
        prev = row_drive;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (row_drive == target && prev != target) ok = 1'b1;
            prev = row_drive;
        end
        check("wait_row", {31'b0, ok}, 32'd1);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NC; k++)
                pressed[r][k] = 1'b0;
        apply_matrix();
    endtask

    // Press one key for hold cycles, release for rel cycles, and compare the
    // resulting key_valid activity with what the key coordinates imply.
    task automatic press_expect(input int r, input int c, input int hold, input int rel,
                                input bit expect_accept);
        int p0, t0;
        p0 = pulses;
        t0 = cycle;
        pressed[r][c] = 1'b1;
        apply_matrix();
        run(hold);
        if (expect_accept) begin
            check("held_while_pressed", {31'b0, key_held}, 32'd1);
        end
        pressed[r][c] = 1'b0;
        apply_matrix();
        run(rel);
        check("pulse_count", 32'(pulses - p0), expect_accept ? 32'd1 : 32'd0);
        if (expect_accept && pulses != p0) begin
            check("key_code", {27'b0, last_code}, 32'(r * NC + c));
            check("row_out", {27'b0, last_row}, 32'(1 << r));
            check("col_out", {28'b0, last_col}, 32'((~(1 << c)) & 4'hF));
            check("latency_ok", {31'b0, (pulse_cycle - t0) <= LAT}, 32'd1);
        end
        check("held_after_release", {31'b0, key_held}, 32'd0);
    endtask

    initial begin
        int p0;
        clear_keys();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_row_drive", {27'b0, row_drive}, 32'h01);
        check("rst_row_out", {27'b0, row_out}, 32'h00);
        check("rst_col_out", {28'b0, col_out}, 32'hF);
        check("rst_key_code", {27'b0, key_code}, 32'd0);
        check("rst_key_valid", {31'b0, key_valid}, 32'd0);
        check("rst_key_held", {31'b0, key_held}, 32'd0);
        rst_n = 1'b1;

        // 1. Idle scan: row advances every SD cycles, wrapping after NR rows.
        for (int k = 1; k <= 100; k++) begin
            step();
            check("scan_row", {27'b0, row_drive}, 32'(1 << ((k / SD) % NR)));
        end
        check("idle_no_valid", 32'(pulses), 32'd0);

        // 2. Key at row 1, col 0, held long: exactly one pulse, no repeat.
        press_expect(1, 0, 120, 30, 1'b1);

        // 3. Short press at row 2, col 3: dropped, scan continues to row 3.
        p0 = pulses;
        wait_row(5'b00100);
        pressed[2][3] = 1'b1;
        apply_matrix();
        run(5);
        pressed[2][3] = 1'b0;
        apply_matrix();
        begin
            bit moved;
            moved = 1'b0;
            for (int i = 0; i < 40 && !moved; i++) begin
                step();
                if (row_drive != 5'b00100) moved = 1'b1;
            end
            check("short_moved", {31'b0, moved}, 32'd1);
            check("short_next_row", {27'b0, row_drive}, 32'h08);
        end
        run(10);
        check("short_no_valid", 32'(pulses - p0), 32'd0);
        check("short_not_held", {31'b0, key_held}, 32'd0);

        // 4. Same key twice with a full release in between.
        p0 = pulses;
        press_expect(1, 1, 40, 30, 1'b1);
        press_expect(1, 1, 40, 30, 1'b1);
        check("double_press_pulses", 32'(pulses - p0), 32'd2);

        // 5. Two columns on one row: ghost/multi-key, ignored.
        p0 = pulses;
        pressed[3][0] = 1'b1;
        pressed[3][1] = 1'b1;
        apply_matrix();
        run(60);
        clear_keys();
        run(10);
        check("multi_no_valid", 32'(pulses - p0), 32'd0);
        check("multi_not_held", {31'b0, key_held}, 32'd0);

        // Randomized presses: long ones must be accepted, short ones not.
        for (int n = 0; n < 12; n++) begin
            int r, c, hold;
            bit long_press;
            r = $urandom_range(0, NR - 1);
            c = $urandom_range(0, NC - 1);
            long_press = ($urandom_range(0, 2) != 0);
            hold = long_press ? $urandom_range(40, 60) : $urandom_range(1, 4);
            press_expect(r, c, hold, $urandom_range(20, 30), long_press);
        end

        // 6. Reset in the middle of a debounce.
        p0 = pulses;
        wait_row(5'b01000);
        pressed[3][2] = 1'b1;
        apply_matrix();
        run(5);
        check("debounce_row_frozen", {27'b0, row_drive}, 32'h08);
        rst_n = 1'b0;
        #1;
        check("mid_rst_row_drive", {27'b0, row_drive}, 32'h01);
        check("mid_rst_row_out", {27'b0, row_out}, 32'h00);
        check("mid_rst_col_out", {28'b0, col_out}, 32'hF);
        check("mid_rst_key_code", {27'b0, key_code}, 32'd0);
        check("mid_rst_key_valid", {31'b0, key_valid}, 32'd0);
        check("mid_rst_key_held", {31'b0, key_held}, 32'd0);
        clear_keys();
        run(3);
        rst_n = 1'b1;
        run(50);
        check("post_rst_no_valid", 32'(pulses - p0), 32'd0);
        check("post_rst_not_held", {31'b0, key_held}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
